// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types, frame constants and helpers for the MCP3008 scan scheduler.
package adc_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int FRAME_PERIODS   = 17;
    localparam int NULL_RISE       = 7;
    localparam int FIRST_DATA_RISE = 8;
    localparam int ADC_W           = 10;
    localparam int NUM_CH          = 8;
    localparam int CH_W            = 3;

    // Command bit for a given AD_CLK period: start, SGL, D2..D0, then zeros.
    function automatic logic cmd_bit(input logic [4:0] period, input logic [CH_W-1:0] ch);
        case (period)
            5'd1, 5'd2: cmd_bit = 1'b1;
            5'd3:       cmd_bit = ch[2];
            5'd4:       cmd_bit = ch[1];
            5'd5:       cmd_bit = ch[0];
            default:    cmd_bit = 1'b0;
        endcase
    endfunction

    // First enabled channel strictly after ptr, wrapping; returns ptr if none.
    function automatic logic [CH_W-1:0] next_scan_ch(input logic [NUM_CH-1:0] mask,
                                                     input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] c;
        logic            found;
        next_scan_ch = ptr;
        found        = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = ptr + CH_W'(i);
            if (!found && mask[c]) begin
                next_scan_ch = c;
                found        = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Priority request / result strobe bundle between requesters and the scheduler.
interface adc_scan_scheduler_if;
    import adc_pkg::*;

    logic              req_valid;
    logic [CH_W-1:0]   req_ch;
    logic              req_ready;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [ADC_W-1:0]  res_data;
    logic              res_prio;

    modport master (output req_valid, req_ch,
                    input  req_ready, res_valid, res_ch, res_data, res_prio);
    modport slave  (input  req_valid, req_ch,
                    output req_ready, res_valid, res_ch, res_data, res_prio);
endinterface

// File: rtl/adc_scan_scheduler_arbiter.sv
// Picks the next conversion: priority port vs round-robin scan, alternating under load.
module adc_req_arbiter
    import adc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arb,
    input  logic [NUM_CH-1:0] i_scan_mask,
    input  logic              i_req_valid,
    input  logic [CH_W-1:0]   i_req_ch,
    output logic              o_grant,
    output logic              o_grant_prio,
    output logic [CH_W-1:0]   o_grant_ch
);
    logic [CH_W-1:0] r_ptr;
    logic            r_last_was_prio;
    logic            w_scan_any;
    logic            w_take_prio;
    logic [CH_W-1:0] w_scan_ch;

    // A pending scan channel always follows a priority conversion.
    always_comb begin
        w_scan_any   = |i_scan_mask;
        w_scan_ch    = next_scan_ch(i_scan_mask, r_ptr);
        w_take_prio  = i_req_valid && !(r_last_was_prio && w_scan_any);
        o_grant      = i_arb && (w_take_prio || w_scan_any);
        o_grant_prio = w_take_prio;
        o_grant_ch   = w_take_prio ? i_req_ch : w_scan_ch;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr           <= CH_W'(NUM_CH - 1);
            r_last_was_prio <= 1'b0;
        end else if (o_grant) begin
            r_last_was_prio <= w_take_prio;
            if (!w_take_prio)
                r_ptr <= w_scan_ch;
        end
    end
endmodule

// File: rtl/adc_scan_scheduler.sv
// MCP3008 frame sequencer: bit-bangs AD_CLK/CS/DIN, captures DOUT, keeps the per-channel table.
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 25,
    parameter int CS_IDLE = 50
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CH-1:0]             i_scan_mask,
    adc_scan_scheduler_if.slave           if_bus,
    output logic                          o_ad_clk,
    output logic                          o_cs,
    output logic                          o_din,
    input  logic                          i_dout,
    output logic [NUM_CH-1:0][ADC_W-1:0]  o_analog_scan
);
    localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [4:0]                     r_period;
    logic                           r_high;
    logic [CH_W-1:0]                r_cur_ch;
    logic                           r_cur_prio;
    logic [ADC_W-1:0]               r_shift;
    logic                           r_done;
    logic                           r_ad_clk;
    logic                           r_cs;
    logic                           r_din;
    logic                           r_req_ready;
    logic                           r_res_valid;
    logic [CH_W-1:0]                r_res_ch;
    logic [ADC_W-1:0]               r_res_data;
    logic                           r_res_prio;
    logic [NUM_CH-1:0][ADC_W-1:0]   r_scan;

    logic                           w_grant;
    logic                           w_grant_prio;
    logic [CH_W-1:0]                w_grant_ch;

    adc_req_arbiter u_arb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_arb        (r_state == IDLE),
        .i_scan_mask  (i_scan_mask),
        .i_req_valid  (if_bus.req_valid),
        .i_req_ch     (if_bus.req_ch),
        .o_grant      (w_grant),
        .o_grant_prio (w_grant_prio),
        .o_grant_ch   (w_grant_ch)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_period    <= '0;
            r_high      <= 1'b0;
            r_cur_ch    <= '0;
            r_cur_prio  <= 1'b0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_ad_clk    <= 1'b0;
            r_cs        <= 1'b1;
            r_din       <= 1'b0;
            r_req_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_res_prio  <= 1'b0;
            r_scan      <= '0;
        end else begin
            r_req_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;

            // Result is published the cycle after CS rises.
            if (r_done) begin
                r_res_valid        <= 1'b1;
                r_res_ch           <= r_cur_ch;
                r_res_data         <= r_shift;
                r_res_prio         <= r_cur_prio;
                r_scan[r_cur_ch]   <= r_shift;
            end

            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= SHIFT;
                        r_req_ready <= w_grant_prio;
                        r_cur_ch    <= w_grant_ch;
                        r_cur_prio  <= w_grant_prio;
                        r_cs        <= 1'b0;
                        r_din       <= 1'b1;
                        r_ad_clk    <= 1'b0;
                        r_period    <= 5'd1;
                        r_high      <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt <= '0;
                        if (!r_high) begin
                            // DOUT is sampled on the edge that raises AD_CLK.
                            r_ad_clk <= 1'b1;
                            r_high   <= 1'b1;
                            if (r_period >= 5'(FIRST_DATA_RISE))
                                r_shift <= {r_shift[ADC_W-2:0], i_dout};
                        end else if (r_period == 5'(FRAME_PERIODS)) begin
                            r_ad_clk <= 1'b0;
                            r_cs     <= 1'b1;
                            r_din    <= 1'b0;
                            r_state  <= GAP;
                            r_done   <= 1'b1;
                        end else begin
                            r_ad_clk <= 1'b0;
                            r_high   <= 1'b0;
                            r_period <= r_period + 5'd1;
                            r_din    <= cmd_bit(r_period + 5'd1, r_cur_ch);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == CNT_W'(CS_IDLE - 1))
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ad_clk         = r_ad_clk;
    assign o_cs             = r_cs;
    assign o_din            = r_din;
    assign o_analog_scan    = r_scan;
    assign if_bus.req_ready = r_req_ready;
    assign if_bus.res_valid = r_res_valid;
    assign if_bus.res_ch    = r_res_ch;
    assign if_bus.res_data  = r_res_data;
    assign if_bus.res_prio  = r_res_prio;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler with a behavioural MCP3008 model.
module tb_adc_scan_scheduler;
    import adc_pkg::*;

    localparam int CLK_DIV = 25;
    localparam int CS_IDLE = 50;
    localparam int SLOT    = 34 * CLK_DIV + CS_IDLE + 1;
    localparam int LAT     = 34 * CLK_DIV + 1;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] data;
        logic       prio;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      scan_mask = 8'h00;
    logic            ad_clk, cs, din;
    logic            adc_dout = 1'b0;
    logic [7:0][9:0] analog_scan;

    adc_scan_scheduler_if bus();

    exp_t       sb[$];
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0, t_grant = 0, t_prev = 0, cs_falls = 0;
    bit         have_prev = 1'b0;
    logic       cs_q = 1'b1;
    logic [9:0] adc_val [8];
    int         rise_n = 0;
    logic [4:0] din_bits = 5'd0;

    always #10 clk = ~clk;

    adc_scan_scheduler #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scan_mask   (scan_mask),
        .if_bus        (bus),
        .o_ad_clk      (ad_clk),
        .o_cs          (cs),
        .o_din         (din),
        .i_dout        (adc_dout),
        .o_analog_scan (analog_scan)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // MCP3008 model: decode command on rises, shift result out on falls.
    always @(negedge cs) begin
        rise_n   = 0;
        din_bits = 5'd0;
        adc_dout = 1'b0;
    end

    always @(posedge ad_clk) if (cs === 1'b0) begin
        rise_n++;
        if (rise_n <= 5) din_bits = {din_bits[3:0], din};
    end

    always @(negedge ad_clk) if (cs === 1'b0) begin
        logic [9:0] v;
        v = adc_val[din_bits[2:0]];
        if (rise_n >= NULL_RISE && rise_n <= FRAME_PERIODS - 1) adc_dout = v[16 - rise_n];
        else adc_dout = 1'b0;
    end

    // Result monitor: every res_valid pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) have_prev = 1'b0;
        if (cs_q === 1'b1 && cs === 1'b0) cs_falls++;
        cs_q = cs;
        if (bus.req_ready === 1'b1) t_grant = cyc;
        if (bus.res_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexp_res", bus.res_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("res_ch",   bus.res_ch,   e.ch);
                chk("res_data", bus.res_data, e.data);
                chk("res_prio", bus.res_prio, e.prio);
                chk("tbl",      analog_scan[e.ch], e.data);
                chk("din_hdr",  din_bits[4:3], 2'b11);
                chk("din_ch",   din_bits[2:0], e.ch);
                if (e.prio) chk("grant_lat", cyc - t_grant, LAT);
                if (have_prev) chk("spacing", cyc - t_prev, SLOT);
                t_prev    = cyc;
                have_prev = 1'b1;
            end
        end
    end

    task automatic push(input logic [2:0] ch, input logic prio);
        exp_t e;
        e.ch   = ch;
        e.data = adc_val[ch];
        e.prio = prio;
        sb.push_back(e);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        scan_mask     = 8'h00;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        have_prev = 1'b0;
    endtask

    initial begin
        int n;
        for (int c = 0; c < 8; c++) adc_val[c] = 10'(c * 97 + 243);
        adc_val[5] = 10'h2A5;
        adc_val[7] = 10'h155;
        bus.req_valid = 1'b0;
        bus.req_ch    = 3'd0;

        // Reset state and silent idle with nothing enabled.
        do_reset();
        chk("rst_cs",        cs, 1);
        chk("rst_adclk",     ad_clk, 0);
        chk("rst_din",       din, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_ch",    bus.res_ch, 0);
        chk("rst_res_data",  bus.res_data, 0);
        chk("rst_res_prio",  bus.res_prio, 0);
        chk("rst_tbl",       |analog_scan, 0);
        cs_falls = 0;
        repeat (10000) @(negedge clk);
        chk("idle_cs_falls", cs_falls, 0);
        chk("idle_cs",       cs, 1);
        chk("idle_adclk",    ad_clk, 0);

        // Two-channel background scan.
        do_reset();
        push(5, 0); push(7, 0); push(5, 0); push(7, 0);
        scan_mask = 8'hA0;
        drain(5 * SLOT);
        scan_mask = 8'h00;
        cs_falls  = 0;
        repeat (1000) @(negedge clk);
        chk("scan_stop", cs_falls, 0);
        chk("tbl5", analog_scan[5], 10'h2A5);
        chk("tbl7", analog_scan[7], 10'h155);

        // Single priority request with scan idle.
        do_reset();
        push(6, 1);
        bus.req_ch    = 3'd6;
        bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_seen", bus.req_ready, 1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("req_ready_1cyc", bus.req_ready, 0);
        drain(2 * SLOT);
        repeat (200) @(negedge clk);

        // Saturated priority plus full scan: strict alternation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(3, 1);
            push(3'(i), 0);
        end
        bus.req_ch    = 3'd3;
        bus.req_valid = 1'b1;
        scan_mask     = 8'hFF;
        drain(17 * SLOT);
        bus.req_valid = 1'b0;
        scan_mask     = 8'h00;
        repeat (1000) @(negedge clk);

        // Reset mid-frame at AD_CLK rise 10; scan restarts from channel 0.
        do_reset();
        push(0, 0);
        scan_mask = 8'h05;
        drain(2 * SLOT);
        n = 0;
        while (!(cs === 1'b0 && rise_n == 10) && n < 3 * SLOT) begin
            @(negedge clk);
            n++;
        end
        chk("rise10_seen", rise_n, 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cs",    cs, 1);
        chk("abort_adclk", ad_clk, 0);
        chk("abort_tbl",   |analog_scan, 0);
        chk("abort_resv",  bus.res_valid, 0);
        push(0, 0); push(2, 0);
        rst_n = 1'b1;
        drain(3 * SLOT);
        scan_mask = 8'h00;
        repeat (1000) @(negedge clk);

        // Mask cleared while ch2 is in flight: result still reported, then silence.
        do_reset();
        push(2, 0);
        scan_mask = 8'h04;
        n = 0;
        while (cs !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ch2_start", cs, 0);
        repeat (100) @(negedge clk);
        scan_mask = 8'h00;
        drain(2 * SLOT);
        cs_falls = 0;
        repeat (2000) @(negedge clk);
        chk("no_more_frames", cs_falls, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
